// File: rtl/trans_tx_fetch_if.sv
// Bundle of the command, TCDM read and TX push signals around the TX fetch engine.
// The master modport is the fetch engine's view; slave is the surrounding system.
interface trans_tx_fetch_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
);
    // command side
    logic                       cmd_req;
    logic                       cmd_gnt;
    logic [ADDR_WIDTH-1:0]      cmd_add;
    logic [LEN_WIDTH-1:0]       cmd_beats;

    // TCDM read side, one port per lane
    logic [1:0]                 tcdm_req;
    logic [1:0][ADDR_WIDTH-1:0] tcdm_add;
    logic [1:0]                 tcdm_wen;
    logic [1:0][3:0]            tcdm_be;
    logic [1:0]                 tcdm_gnt;
    logic [1:0]                 tcdm_r_valid;
    logic [1:0][31:0]           tcdm_r_data;

    // TX buffer push side, one lane per 32-bit half of a beat
    logic [1:0][31:0]           tx_data_push_dat;
    logic [1:0]                 tx_data_push_req;
    logic [1:0]                 tx_data_push_gnt;

    // status
    logic                       busy;
    logic                       done;

    modport master (
        input  cmd_req, cmd_add, cmd_beats,
        output cmd_gnt,
        output tcdm_req, tcdm_add, tcdm_wen, tcdm_be,
        input  tcdm_gnt, tcdm_r_valid, tcdm_r_data,
        output tx_data_push_dat, tx_data_push_req,
        input  tx_data_push_gnt,
        output busy, done
    );

    modport slave (
        output cmd_req, cmd_add, cmd_beats,
        input  cmd_gnt,
        input  tcdm_req, tcdm_add, tcdm_wen, tcdm_be,
        output tcdm_gnt, tcdm_r_valid, tcdm_r_data,
        input  tx_data_push_dat, tx_data_push_req,
        output tx_data_push_gnt,
        input  busy, done
    );
endinterface

// File: rtl/trans_tx_fetch.sv
// TCDM-side read engine for the TX path of the transfer unit.
// A command (base address, beat count) is turned into paired 32-bit TCDM reads:
// lane0 fetches the low word and lane1 the high word of each 64-bit beat.
// Each lane has its own issue counter, one-deep outstanding tracker and a
// 2-entry holding queue, so lanes progress independently and only meet again
// when the whole transfer has drained.
module trans_tx_fetch #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    trans_tx_fetch_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                     state_q, state_d;

    // registered command
    logic [LEN_WIDTH-1:0]       beats_q;

    // per-lane control
    logic [1:0][LEN_WIDTH-1:0]  k_q;       // reads granted so far
    logic [1:0][ADDR_WIDTH-1:0] addr_q;    // address of the next read
    logic [1:0]                 outst_q;   // read granted last cycle, response due now
    logic [1:0][1:0]            occ_q;     // holding queue fill level (0..2)
    logic [1:0]                 wr_ptr_q;
    logic [1:0]                 rd_ptr_q;

    // per-lane holding queue storage; validity is tracked by occ_q
    logic [1:0][1:0][31:0]      mem_q;

    logic                       cmd_hs;
    logic [ADDR_WIDTH-1:0]      base_aligned;
    logic [1:0]                 issue;
    logic [1:0]                 tcdm_hs;
    logic [1:0]                 wr_en;
    logic [1:0]                 pop;
    logic [1:0]                 drained;
    logic [1:0][31:0]           push_dat;

    assign cmd_hs       = bus.cmd_req & (state_q == IDLE);
    // beats are 64-bit aligned, so the low three address bits are forced to zero
    assign base_aligned = bus.cmd_add & ~ADDR_WIDTH'(7);

    // Per-lane issue, capture, pop and drain decisions.
    always_comb begin
        issue    = '0;
        tcdm_hs  = '0;
        wr_en    = '0;
        pop      = '0;
        drained  = '0;
        push_dat = '0;
        for (int i = 0; i < 2; i++) begin
            pop[i]     = (occ_q[i] != 2'd0) & bus.tx_data_push_gnt[i];
            wr_en[i]   = bus.tcdm_r_valid[i] & outst_q[i];
            // A new read is allowed only if its response is guaranteed a slot:
            // queued words plus the response in flight, minus this cycle's pop.
            issue[i]   = (state_q == RUN) && (k_q[i] < beats_q) &&
                         (({1'b0, occ_q[i]} + {2'b00, outst_q[i]}) < (3'd2 + {2'b00, pop[i]}));
            tcdm_hs[i] = issue[i] & bus.tcdm_gnt[i];
            // Lane is finished once every read is granted, answered and pushed;
            // a pop of the last queued word in this cycle already counts.
            drained[i] = (k_q[i] == beats_q) && !outst_q[i] && (occ_q[i] == {1'b0, pop[i]});
            if (occ_q[i] != 2'd0) begin
                push_dat[i] = mem_q[i][rd_ptr_q[i]];
            end
        end
    end

    // Transfer state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Transfer sequencing: zero-beat commands complete without touching the TCDM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cmd_hs) begin
                    state_d = (bus.cmd_beats != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (&drained) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Command capture so later changes on the command inputs are ignored.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            beats_q <= '0;
        end else if (cmd_hs) begin
            beats_q <= bus.cmd_beats;
        end
    end

    // Per-lane issue counter, address, outstanding flag and queue pointers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            k_q      <= '0;
            addr_q   <= '0;
            outst_q  <= '0;
            occ_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            outst_q <= tcdm_hs;
            for (int i = 0; i < 2; i++) begin
                if (cmd_hs) begin
                    k_q[i]    <= '0;
                    addr_q[i] <= base_aligned + ADDR_WIDTH'(4 * i);
                end else if (tcdm_hs[i]) begin
                    k_q[i]    <= k_q[i] + LEN_WIDTH'(1);
                    addr_q[i] <= addr_q[i] + ADDR_WIDTH'(8);
                end
                if (wr_en[i]) begin
                    wr_ptr_q[i] <= ~wr_ptr_q[i];
                end
                if (pop[i]) begin
                    rd_ptr_q[i] <= ~rd_ptr_q[i];
                end
                case ({wr_en[i], pop[i]})
                    2'b10:   occ_q[i] <= occ_q[i] + 2'd1;
                    2'b01:   occ_q[i] <= occ_q[i] - 2'd1;
                    default: occ_q[i] <= occ_q[i];
                endcase
            end
        end
    end

    // Holding queue storage: read responses land here at the clock edge.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 2; i++) begin
            if (wr_en[i]) begin
                mem_q[i][wr_ptr_q[i]] <= bus.tcdm_r_data[i];
            end
        end
    end

    assign bus.cmd_gnt          = (state_q == IDLE);
    assign bus.tcdm_req         = issue;
    assign bus.tcdm_add         = addr_q;
    assign bus.tcdm_wen         = 2'b11;
    assign bus.tcdm_be          = {4'hF, 4'hF};
    assign bus.tx_data_push_req = {(occ_q[1] != 2'd0), (occ_q[0] != 2'd0)};
    assign bus.tx_data_push_dat = push_dat;
    assign bus.busy             = (state_q != IDLE);
    assign bus.done             = (state_q == DONE);

endmodule

// File: tb/tb_trans_tx_fetch.sv
// Self-checking bench for trans_tx_fetch: a TCDM responder with fixed one-cycle
// read latency, a scoreboard of expected addresses and push data per lane, and
// one task per scenario.
module tb_trans_tx_fetch;
    localparam int AW = 32;
    localparam int LW = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    trans_tx_fetch_if #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

    trans_tx_fetch #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [31:0] exp_add [2][$];
    logic [31:0] exp_dat [2][$];

    // environment knobs
    bit       gnt0_alt = 1'b0;
    int       stall1   = 0;
    logic [1:0] extra_rv = 2'b00;

    // responder state
    logic [1:0]  pend_v = 2'b00;
    logic [31:0] pend_d [2];

    // observations
    int hs_cyc    = 0;
    int done_cnt  = 0;
    int done_cyc  = 0;
    int issue_cnt [2] = '{0, 0};
    int push_cnt  [2] = '{0, 0};
    int req_seen  [2] = '{0, 0};
    int first_req_cyc  [2] = '{-1, -1};
    int first_push_cyc [2] = '{-1, -1};
    int last_push_cyc  [2] = '{0, 0};
    bit prev_stall [2] = '{1'b0, 1'b0};
    logic [31:0] prev_add [2];
    logic [31:0] ea;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    // Environment driver: grants, TX back-pressure, read responses (1 cycle after grant).
    always @(posedge clk) begin
        cyc++;
        #1;
        for (int i = 0; i < 2; i++) begin
            bus.tcdm_r_valid[i] = pend_v[i] | extra_rv[i];
            bus.tcdm_r_data[i]  = pend_v[i] ? pend_d[i] : 32'hBAD0_0000;
            pend_v[i] = 1'b0;
        end
        bus.tcdm_gnt[0]         = gnt0_alt ? cyc[0] : 1'b1;
        bus.tcdm_gnt[1]         = 1'b1;
        bus.tx_data_push_gnt[0] = 1'b1;
        bus.tx_data_push_gnt[1] = (stall1 > 0) ? 1'b0 : 1'b1;
        if (stall1 > 0) stall1--;
    end

    // Monitor and scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.cmd_req && bus.cmd_gnt) hs_cyc = cyc;
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        for (int i = 0; i < 2; i++) begin
            if (prev_stall[i] && rst_n) begin
                checks++;
                if (bus.tcdm_req[i] !== 1'b1 || bus.tcdm_add[i] !== prev_add[i]) begin
                    errors++;
                    $display("FAIL addr_hold lane%0d: got req=%b add=%h, want req=1 add=%h",
                             i, bus.tcdm_req[i], bus.tcdm_add[i], prev_add[i]);
                end
            end
            prev_stall[i] = rst_n && bus.tcdm_req[i] && !bus.tcdm_gnt[i];
            prev_add[i]   = bus.tcdm_add[i];
            if (bus.tcdm_req[i]) req_seen[i]++;
            if (bus.tcdm_req[i] && bus.tcdm_gnt[i]) begin
                issue_cnt[i]++;
                if (first_req_cyc[i] < 0) first_req_cyc[i] = cyc;
                checks++;
                if (exp_add[i].size() == 0) begin
                    errors++;
                    $display("FAIL tcdm_add lane%0d: unexpected read at %h, none expected", i, bus.tcdm_add[i]);
                end else begin
                    ea = exp_add[i].pop_front();
                    if (bus.tcdm_add[i] !== ea) begin
                        errors++;
                        $display("FAIL tcdm_add lane%0d: got %h, want %h", i, bus.tcdm_add[i], ea);
                    end
                end
                pend_v[i] = 1'b1;
                pend_d[i] = memf(bus.tcdm_add[i]);
            end
            if (bus.tx_data_push_req[i] && bus.tx_data_push_gnt[i]) begin
                push_cnt[i]++;
                last_push_cyc[i] = cyc;
                if (first_push_cyc[i] < 0) first_push_cyc[i] = cyc;
                checks++;
                if (exp_dat[i].size() == 0) begin
                    errors++;
                    $display("FAIL push_dat lane%0d: unexpected push of %h, none expected", i, bus.tx_data_push_dat[i]);
                end else begin
                    ea = exp_dat[i].pop_front();
                    if (bus.tx_data_push_dat[i] !== ea) begin
                        errors++;
                        $display("FAIL push_dat lane%0d: got %h, want %h", i, bus.tx_data_push_dat[i], ea);
                    end
                end
            end
        end
    end

    task automatic start_cmd(input logic [31:0] base, input int n);
        logic [31:0] b;
        logic [31:0] a;
        b = base & ~32'h7;
        for (int k = 0; k < n; k++) begin
            a = b + 32'(8 * k);
            exp_add[0].push_back(a);
            exp_dat[0].push_back(memf(a));
            a = a + 32'h4;
            exp_add[1].push_back(a);
            exp_dat[1].push_back(memf(a));
        end
        first_req_cyc  = '{-1, -1};
        first_push_cyc = '{-1, -1};
        bus.cmd_req   = 1'b1;
        bus.cmd_add   = base;
        bus.cmd_beats = n[15:0];
        @(posedge clk); #1;
        bus.cmd_req   = 1'b0;
        bus.cmd_add   = 32'hDEAD_0000;
        bus.cmd_beats = 16'hFFFF;
    endtask

    task automatic wait_done(input int start_cnt, input int budget, output bit ok);
        int t;
        t = 0;
        while (done_cnt == start_cnt && t < budget) begin
            @(posedge clk);
            t++;
        end
        ok = (done_cnt != start_cnt);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.cmd_gnt !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: gnt=%b busy=%b done=%b, want 1 0 0", bus.cmd_gnt, bus.busy, bus.done);
        end
        checks++;
        if (bus.tcdm_req !== 2'b00 || bus.tcdm_add !== 64'h0 || bus.tcdm_wen !== 2'b11 || bus.tcdm_be !== 8'hFF ||
            bus.tx_data_push_req !== 2'b00 || bus.tx_data_push_dat !== 64'h0) begin
            errors++;
            $display("FAIL reset_outputs: req=%b add=%h wen=%b be=%h preq=%b pdat=%h, want 00 0 11 ff 00 0",
                     bus.tcdm_req, bus.tcdm_add, bus.tcdm_wen, bus.tcdm_be, bus.tx_data_push_req, bus.tx_data_push_dat);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int d0, p0, p1;
        bit ok;
        d0 = done_cnt; p0 = push_cnt[0]; p1 = push_cnt[1];
        start_cmd(32'h0000_1000, 4);
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1 || bus.cmd_gnt !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy: busy=%b gnt=%b, want 1 0", bus.busy, bus.cmd_gnt);
        end
        wait_done(d0, 40, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_timeout: done_o not seen, want one within 40 cycles"); end
        checks++;
        if (done_cyc - hs_cyc !== 7) begin
            errors++;
            $display("FAIL basic_done_latency: got %0d, want 7", done_cyc - hs_cyc);
        end
        checks++;
        if (first_req_cyc[0] - hs_cyc !== 1 || first_req_cyc[1] - hs_cyc !== 1) begin
            errors++;
            $display("FAIL basic_req_latency: got %0d/%0d, want 1/1", first_req_cyc[0] - hs_cyc, first_req_cyc[1] - hs_cyc);
        end
        checks++;
        if (first_push_cyc[0] - hs_cyc !== 3 || first_push_cyc[1] - hs_cyc !== 3) begin
            errors++;
            $display("FAIL basic_push_latency: got %0d/%0d, want 3/3", first_push_cyc[0] - hs_cyc, first_push_cyc[1] - hs_cyc);
        end
        repeat (2) @(posedge clk); #1;
        checks++;
        if (push_cnt[0] - p0 !== 4 || push_cnt[1] - p1 !== 4) begin
            errors++;
            $display("FAIL basic_push_count: got %0d/%0d, want 4/4", push_cnt[0] - p0, push_cnt[1] - p1);
        end
        checks++;
        if (exp_add[0].size() + exp_add[1].size() + exp_dat[0].size() + exp_dat[1].size() !== 0) begin
            errors++;
            $display("FAIL basic_leftover: got %0d pending items, want 0",
                     exp_add[0].size() + exp_add[1].size() + exp_dat[0].size() + exp_dat[1].size());
        end
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL basic_done_count: got %0d, want 1", done_cnt - d0);
        end
    endtask

    task automatic test_push_stall();
        int d0, i0, i1, p1;
        bit ok;
        d0 = done_cnt; i0 = issue_cnt[0]; i1 = issue_cnt[1]; p1 = push_cnt[1];
        stall1 = 12;
        start_cmd(32'h0000_2000, 3);
        repeat (6) @(posedge clk); #1;
        checks++;
        if (issue_cnt[1] - i1 !== 2 || issue_cnt[0] - i0 !== 3) begin
            errors++;
            $display("FAIL stall_issue: lane0=%0d lane1=%0d reads, want 3 2", issue_cnt[0] - i0, issue_cnt[1] - i1);
        end
        wait_done(d0, 60, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL stall_timeout: done_o not seen, want one within 60 cycles"); end
        repeat (2) @(posedge clk); #1;
        checks++;
        if (push_cnt[1] - p1 !== 3) begin
            errors++;
            $display("FAIL stall_push_count: got %0d, want 3", push_cnt[1] - p1);
        end
        checks++;
        if (done_cyc !== last_push_cyc[1] + 1) begin
            errors++;
            $display("FAIL stall_done_after_push: done cycle %0d, want %0d", done_cyc, last_push_cyc[1] + 1);
        end
    endtask

    task automatic test_zero_beats();
        int d0, r0, r1;
        d0 = done_cnt; r0 = req_seen[0]; r1 = req_seen[1];
        start_cmd(32'h0000_4000, 0);
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b1 || bus.cmd_gnt !== 1'b0) begin
            errors++;
            $display("FAIL zero_done: done=%b gnt=%b in cycle 1, want 1 0", bus.done, bus.cmd_gnt);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.cmd_gnt !== 1'b1) begin
            errors++;
            $display("FAIL zero_regnt: done=%b gnt=%b in cycle 2, want 0 1", bus.done, bus.cmd_gnt);
        end
        @(posedge clk); #1;
        checks++;
        if (req_seen[0] - r0 !== 0 || req_seen[1] - r1 !== 0 || done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL zero_traffic: reqs=%0d/%0d dones=%0d, want 0/0 1",
                     req_seen[0] - r0, req_seen[1] - r1, done_cnt - d0);
        end
    endtask

    task automatic test_gnt_gaps();
        int d0, p0, p1;
        bit ok;
        d0 = done_cnt; p0 = push_cnt[0]; p1 = push_cnt[1];
        gnt0_alt = 1'b1;
        start_cmd(32'h0000_3005, 6);
        wait_done(d0, 80, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL gaps_timeout: done_o not seen, want one within 80 cycles"); end
        repeat (3) @(posedge clk); #1;
        gnt0_alt = 1'b0;
        checks++;
        if (push_cnt[0] - p0 !== 6 || push_cnt[1] - p1 !== 6) begin
            errors++;
            $display("FAIL gaps_push_count: got %0d/%0d, want 6/6", push_cnt[0] - p0, push_cnt[1] - p1);
        end
        checks++;
        if (!(last_push_cyc[1] < last_push_cyc[0])) begin
            errors++;
            $display("FAIL gaps_lane1_early: lane1 last push %0d, want before lane0 %0d", last_push_cyc[1], last_push_cyc[0]);
        end
        checks++;
        if (done_cnt - d0 !== 1 || done_cyc !== last_push_cyc[0] + 1) begin
            errors++;
            $display("FAIL gaps_done: count=%0d cycle=%0d, want 1 at %0d", done_cnt - d0, done_cyc, last_push_cyc[0] + 1);
        end
    endtask

    task automatic test_addr_wrap();
        int d0;
        bit ok;
        d0 = done_cnt;
        start_cmd(32'hFFFF_FFF8, 2);
        wait_done(d0, 30, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL wrap_timeout: done_o not seen, want one within 30 cycles"); end
        checks++;
        if (done_cyc - hs_cyc !== 5) begin
            errors++;
            $display("FAIL wrap_done_latency: got %0d, want 5", done_cyc - hs_cyc);
        end
        repeat (2) @(posedge clk); #1;
        checks++;
        if (exp_dat[0].size() + exp_dat[1].size() !== 0) begin
            errors++;
            $display("FAIL wrap_leftover: got %0d pending pushes, want 0", exp_dat[0].size() + exp_dat[1].size());
        end
    endtask

    task automatic test_reset_mid();
        int d0, p0, p1, r0, r1;
        bit ok;
        start_cmd(32'h0000_5000, 8);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp_add[i].delete();
            exp_dat[i].delete();
        end
        d0 = done_cnt; p0 = push_cnt[0]; p1 = push_cnt[1];
        extra_rv = 2'b11;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.cmd_gnt !== 1'b1 || bus.tcdm_req !== 2'b00 ||
            bus.tx_data_push_req !== 2'b00 || bus.tx_data_push_dat !== 64'h0 || bus.tcdm_add !== 64'h0) begin
            errors++;
            $display("FAIL midrst_outputs: busy=%b gnt=%b req=%b preq=%b pdat=%h add=%h, want 0 1 00 00 0 0",
                     bus.busy, bus.cmd_gnt, bus.tcdm_req, bus.tx_data_push_req, bus.tx_data_push_dat, bus.tcdm_add);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        r0 = req_seen[0]; r1 = req_seen[1];
        repeat (3) @(posedge clk); #1;
        extra_rv = 2'b00;
        repeat (3) @(posedge clk); #1;
        checks++;
        if (push_cnt[0] - p0 !== 0 || push_cnt[1] - p1 !== 0 || done_cnt - d0 !== 0) begin
            errors++;
            $display("FAIL midrst_quiet: pushes=%0d/%0d dones=%0d, want 0/0 0", push_cnt[0] - p0, push_cnt[1] - p1, done_cnt - d0);
        end
        checks++;
        if (req_seen[0] - r0 !== 0 || req_seen[1] - r1 !== 0 || bus.cmd_gnt !== 1'b1) begin
            errors++;
            $display("FAIL midrst_idle: reqs=%0d/%0d gnt=%b, want 0/0 1", req_seen[0] - r0, req_seen[1] - r1, bus.cmd_gnt);
        end
        d0 = done_cnt; p0 = push_cnt[0];
        start_cmd(32'h0000_6000, 2);
        wait_done(d0, 30, ok);
        checks++;
        if (!ok || done_cyc - hs_cyc !== 5) begin
            errors++;
            $display("FAIL midrst_next_cmd: done seen=%0d latency=%0d, want 1 5", ok, done_cyc - hs_cyc);
        end
        repeat (2) @(posedge clk); #1;
        checks++;
        if (push_cnt[0] - p0 !== 2) begin
            errors++;
            $display("FAIL midrst_next_push: got %0d, want 2", push_cnt[0] - p0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_req   = 1'b0;
        bus.cmd_add   = '0;
        bus.cmd_beats = '0;
        test_reset();
        test_basic();
        test_push_stall();
        test_zero_beats();
        test_gnt_gaps();
        test_addr_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
